mem_responder64: RTL

Memory-backed bus responder for the 64-bit VProc bus. It sits on the far end of a VProc64 initiator and accepts single-word and burst reads and writes into an internal word array. It returns RDAck/WRAck after a programmable number of wait states, honours byte enables, and checks burst framing. It is the standard target for co-simulation test harnesses that need real storage behind a virtual processor.

---
 rtl/mem_responder64.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_responder64.sv
// Memory-backed responder for the 64-bit VProc bus: word array with byte enables,
// programmable read/write wait states, Stall backpressure and burst framing checks.
module mem_responder64 #(
    parameter int MEM_AW   = 10,
    parameter int ADDR_LSB = 3,
    parameter int RD_WAIT  = 1,
    parameter int WR_WAIT  = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [63:0] Addr,
    input  logic [7:0]  BE,
    input  logic        WE,
    input  logic        RD,
    input  logic [63:0] DataOut,
    output logic [63:0] DataIn,
    output logic        WRAck,
    output logic        RDAck,
    input  logic [11:0] Burst,
    input  logic        BurstFirst,
    input  logic        BurstLast,
    input  logic        Stall,
    input  logic        ErrClr,
    output logic        Error,
    output logic [11:0] Remaining
);

    localparam logic [3:0] RD_W = 4'(RD_WAIT);
    localparam logic [3:0] WR_W = 4'(WR_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        access;
    logic        wr_ack_q, rd_ack_q, err_q;
    logic [63:0] data_in_q;
    logic [11:0] rem_q, rem_d;
    logic        err_set;
    logic        oor, both, mem_we;
    logic [MEM_AW-1:0] word_idx;

    logic [63:0] mem [2**MEM_AW];

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^Addr[ADDR_LSB-1:0];

    assign word_idx = Addr[ADDR_LSB +: MEM_AW];
    assign oor      = |Addr[63:ADDR_LSB+MEM_AW];
    assign both     = WE && RD;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (WE || RD) begin
                    cnt_d = WE ? WR_W : RD_W;
                    if (cnt_d == 4'd0 && !Stall) begin
                        access  = 1'b1;
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!Stall) begin
                    if (cnt_q <= 4'd1) begin
                        access  = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = S_ACK;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Burst bookkeeping for the beat being accessed this cycle.
    always_comb begin
        rem_d = rem_q;
        if (BurstFirst)
            rem_d = Burst - 12'd1;
        else if (rem_q != 12'd0)
            rem_d = rem_q - 12'd1;
        err_set = access && ((oor && (WE || RD)) || both
                             || (BurstLast && rem_d != 12'd0)
                             || (!BurstFirst && Burst != 12'd0 && rem_q == 12'd0));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            data_in_q <= 64'd0;
            rem_q     <= 12'd0;
            err_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ack_q <= access && WE;
            rd_ack_q <= access && RD;
            if (access && RD)
                data_in_q <= (both || oor) ? 64'd0 : mem[word_idx];
            if (access)
                rem_q <= rem_d;
            if (err_set)
                err_q <= 1'b1;
            else if (ErrClr)
                err_q <= 1'b0;
        end
    end

    // A write landing on the same edge as Reset is aborted.
    assign mem_we = access && WE && !RD && !oor && !Reset;

    // NOTE: the storage array has no reset; contents survive Reset and start undefined.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (BE[b])
                    mem[word_idx][8*b +: 8] <= DataOut[8*b +: 8];
            end
        end
    end

    assign DataIn    = data_in_q;
    assign WRAck     = wr_ack_q;
    assign RDAck     = rd_ack_q;
    assign Error     = err_q;
    assign Remaining = rem_q;

endmodule
